// File: rtl/opsum_requant_packer_if.sv
// Stream bundle for opsum_requant_packer: opsum input stream from the PE
// and packed ofmap output stream toward the GLB writer.
// master = the side that produces opsums and consumes ofmap words.
// slave  = the requant/packer block.
interface opsum_requant_packer_if;
    logic [31:0] opsum_in;
    logic        opsum_in_last;
    logic        opsum_in_valid;
    logic        opsum_in_ready;
    logic [31:0] ofmap_out;
    logic [3:0]  ofmap_keep;
    logic        ofmap_valid;
    logic        ofmap_ready;

    modport master (
        output opsum_in, opsum_in_last, opsum_in_valid, ofmap_ready,
        input  opsum_in_ready, ofmap_out, ofmap_keep, ofmap_valid
    );

    modport slave (
        input  opsum_in, opsum_in_last, opsum_in_valid, ofmap_ready,
        output opsum_in_ready, ofmap_out, ofmap_keep, ofmap_valid
    );
endinterface

// File: rtl/opsum_requant_packer.sv
// opsum_requant_packer
// Requantizes signed 32-bit opsums to int8 (multiply, round-half-up
// arithmetic shift, saturate), re-biases to uint8 (XOR 0x80) and packs
// four bytes per 32-bit ofmap word. A "last" opsum flushes a partial word.
// Pipeline: S1 multiply register -> S2 requant + pack slot -> output register.
// Every stage advances together on adv = !ofmap_valid | ofmap_ready.
// Optional feature: define OPSUM_RELU_EN to clamp to [0,127] instead of
// the full int8 range.
module opsum_requant_packer #(
    parameter int SCALE_BITS = 16,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [SCALE_BITS-1:0] cfg_scale,
    input  logic [4:0]            cfg_shift,
    opsum_requant_packer_if.slave bus,
    output logic                  busy,
    output logic [CNT_BITS-1:0]   word_cnt
);
    // Product kept one bit wider than the strict 32+SCALE_BITS so the full
    // multiply result is stored without a dropped (unused) top bit.
    localparam int PROD_W = 33 + SCALE_BITS;

    // Configuration and counter state
    logic [SCALE_BITS-1:0] scale_q, scale_d;
    logic [4:0]            shift_q, shift_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    // S1 state
    logic                  v1_q, v1_d;
    logic                  last1_q, last1_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;

    // Pack state
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            slot_q [3];
    logic [7:0]            slot_d [3];

    // Output register
    logic [31:0]           out_q, out_d;
    logic [3:0]            keep_q, keep_d;
    logic                  valid_q, valid_d;

    logic                  adv;
    logic signed [PROD_W-1:0] prod_full;
    logic signed [PROD_W:0]   rnd;
    logic signed [PROD_W:0]   sum;
    logic signed [PROD_W:0]   shifted;
    logic [7:0]            q_byte;
    logic [7:0]            new_byte;
    logic [7:0]            lane [4];
    logic [3:0]            keep_next;

    assign adv       = !valid_q | bus.ofmap_ready;
    assign prod_full = $signed(bus.opsum_in) * $signed({1'b0, scale_q});

    // S1: capture the product of an accepted opsum, or drain the stage
    always_comb begin
        v1_d    = v1_q;
        last1_d = last1_q;
        prod_d  = prod_q;
        if (adv) begin
            v1_d = bus.opsum_in_valid;
            if (bus.opsum_in_valid) begin
                prod_d  = prod_full;
                last1_d = bus.opsum_in_last;
            end
        end
    end

    // S2: round-half-up arithmetic shift, saturate, re-bias to uint8
    always_comb begin
        rnd = '0;
        if (shift_q != 5'd0) begin
            rnd[shift_q - 5'd1] = 1'b1;
        end
        sum     = {prod_q[PROD_W-1], prod_q} + rnd;
        shifted = sum >>> shift_q;
`ifdef OPSUM_RELU_EN
        if (shifted < 0) begin
            q_byte = 8'h00;
        end else if (shifted > 127) begin
            q_byte = 8'h7F;
        end else begin
            q_byte = shifted[7:0];
        end
`else
        if (shifted > 127) begin
            q_byte = 8'h7F;
        end else if (shifted < -128) begin
            q_byte = 8'h80;
        end else begin
            q_byte = shifted[7:0];
        end
`endif
        new_byte = q_byte ^ 8'h80;
    end

    // Word assembly: lanes below idx come from slots, lane idx is the
    // incoming byte, lanes above idx are zero; keep covers lanes 0..idx.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        if (gi < 3) begin : g_slot_lane
            assign lane[gi] = (idx_q > 2'(gi))  ? slot_q[gi] :
                              (idx_q == 2'(gi)) ? new_byte   : 8'h00;
        end else begin : g_top_lane
            assign lane[gi] = (idx_q == 2'd3) ? new_byte : 8'h00;
        end
        assign keep_next[gi] = (idx_q >= 2'(gi));
    end

    // Pack slots and output register update
    always_comb begin
        idx_d   = idx_q;
        slot_d  = slot_q;
        out_d   = out_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        if (valid_q && bus.ofmap_ready) begin
            valid_d = 1'b0;
        end
        if (adv && v1_q) begin
            if (idx_q == 2'd3 || last1_q) begin
                out_d   = {lane[3], lane[2], lane[1], lane[0]};
                keep_d  = keep_next;
                valid_d = 1'b1;
                idx_d   = 2'd0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (idx_q == 2'(i)) begin
                        slot_d[i] = new_byte;
                    end
                end
                idx_d = idx_q + 2'd1;
            end
        end
    end

    // Configuration latch (idle only) and emitted-word counter
    always_comb begin
        scale_d = scale_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (cfg_load && !busy) begin
            scale_d = cfg_scale;
            shift_d = cfg_shift;
            cnt_d   = '0;
        end else if (valid_q && bus.ofmap_ready) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    // State registers; reset discards all in-flight data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            prod_q  <= '0;
            idx_q   <= 2'd0;
            slot_q  <= '{default: 8'h00};
            out_q   <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            scale_q <= scale_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            prod_q  <= prod_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            out_q   <= out_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign bus.opsum_in_ready = adv;
    assign bus.ofmap_out      = out_q;
    assign bus.ofmap_keep     = keep_q;
    assign bus.ofmap_valid    = valid_q;
    assign busy               = v1_q | (idx_q != 2'd0) | valid_q;
    assign word_cnt           = cnt_q;
endmodule

// File: tb/tb_opsum_requant_packer.sv
// Testbench for opsum_requant_packer: table-driven vectors plus
// hand-written sequences (latency, backpressure, cfg while busy,
// counter wrap, reset mid-word), checked through a scoreboard queue.
module tb_opsum_requant_packer;
    localparam int CNT_BITS = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_load = 1'b0;
    logic [15:0]         cfg_scale = '0;
    logic [4:0]          cfg_shift = '0;
    logic                busy;
    logic [CNT_BITS-1:0] word_cnt;

    opsum_requant_packer_if bus();

    opsum_requant_packer #(.SCALE_BITS(16), .CNT_BITS(CNT_BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_load (cfg_load),
        .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift),
        .bus      (bus),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  keep;
    } exp_t;

    typedef struct packed {
        logic [15:0]       scale;
        logic [4:0]        shift;
        logic [2:0]        n;
        logic [3:0][31:0]  ops;
        logic              last;
        logic [31:0]       word;
        logic [3:0]        keep;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   words_seen = 0;
    int   cnt_model = 0;

    // Bench reference state
    int          m_scale = 0;
    int          m_shift = 0;
    int          m_idx = 0;
    logic [7:0]  m_bytes [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int opsum, input int scale, input int shift);
        longint p;
        logic [63:0] pb;
        p = longint'(opsum) * longint'(scale);
        if (shift > 0) p = p + (longint'(1) << (shift - 1));
        p = p >>> shift;
`ifdef OPSUM_RELU_EN
        if (p < 0) p = 0;
`else
        if (p < -128) p = -128;
`endif
        if (p > 127) p = 127;
        pb = p;
        return pb[7:0] ^ 8'h80;
    endfunction

    function automatic vec_t mk(input int scale, input int shift, input int n,
                                input int o0, input int o1, input int o2, input int o3,
                                input logic last, input logic [31:0] word, input logic [3:0] keep);
        vec_t v;
        v.scale = 16'(scale);
        v.shift = 5'(shift);
        v.n     = 3'(n);
        v.ops   = {32'(o3), 32'(o2), 32'(o1), 32'(o0)};
        v.last  = last;
        v.word  = word;
        v.keep  = keep;
        return v;
    endfunction

    // Scoreboard monitor: pop and compare each accepted word, and check that
    // a stalled word stays stable until accepted.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;
    logic [3:0]  prev_keep  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, bus.ofmap_valid}, 32'd1);
                chk("stall_word", bus.ofmap_out, prev_word);
                chk("stall_keep", {28'd0, bus.ofmap_keep}, {28'd0, prev_keep});
            end
            if (bus.ofmap_valid && bus.ofmap_ready) begin
                words_seen++;
                cnt_model++;
                $display("word %0d: out=%h keep=%h", words_seen, bus.ofmap_out, bus.ofmap_keep);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", bus.ofmap_out);
                end else begin
                    e = sb.pop_front();
                    chk("word", bus.ofmap_out, e.word);
                    chk("keep", {28'd0, bus.ofmap_keep}, {28'd0, e.keep});
                end
            end
            prev_stall = bus.ofmap_valid && !bus.ofmap_ready;
            prev_word  = bus.ofmap_out;
            prev_keep  = bus.ofmap_keep;
        end
    end

    // Present one opsum and hold it until accepted; optionally model it.
    task automatic send(input int d, input logic l, input logic do_model);
        logic acc;
        exp_t e;
        int   k;
        if (do_model) begin
            m_bytes[m_idx] = ref_byte(d, m_scale, m_shift);
            if (m_idx == 3 || l) begin
                e.word = '0;
                for (k = 0; k <= m_idx; k++) e.word[8*k +: 8] = m_bytes[k];
                e.keep = 4'((1 << (m_idx + 1)) - 1);
                sb.push_back(e);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        bus.opsum_in       = d;
        bus.opsum_in_last  = l;
        bus.opsum_in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = bus.opsum_in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
        bus.opsum_in_valid = 1'b0;
        bus.opsum_in_last  = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !busy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending=%0d busy=%0b expected 0/0", sb.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int scale, input int shift);
        drain();
        cfg_scale = 16'(scale);
        cfg_shift = 5'(shift);
        cfg_load  = 1'b1;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        m_scale   = scale;
        m_shift   = shift;
        cnt_model = 0;
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = mk(1, 0, 4, 5, -3, 200, -500, 1'b0, 32'h00FF7D85, 4'hF);
        tbl[1] = mk(3, 2, 4, 7, -7, 0, 2,      1'b1, 32'h82807B85, 4'hF);
        tbl[2] = mk(1, 0, 2, 10, 20, 0, 0,     1'b1, 32'h0000948A, 4'h3);
`ifdef OPSUM_RELU_EN
        tbl[3] = mk(1, 0, 4, -3, 4, -128, 127, 1'b0, 32'hFF808480, 4'hF);
        tbl[7] = mk(65535, 0, 1, 32'h80000000, 0, 0, 0, 1'b1, 32'h00000080, 4'h1);
        tbl[4] = mk(1, 0, 1, -1, 0, 0, 0,      1'b1, 32'h00000080, 4'h1);
`else
        tbl[3] = mk(1, 0, 4, -3, 4, -128, 127, 1'b0, 32'hFF00847D, 4'hF);
        tbl[7] = mk(65535, 0, 1, 32'h80000000, 0, 0, 0, 1'b1, 32'h00000000, 4'h1);
        tbl[4] = mk(1, 0, 1, -1, 0, 0, 0,      1'b1, 32'h0000007F, 4'h1);
`endif
        tbl[5] = mk(65535, 31, 1, 32'h7FFFFFFF, 0, 0, 0, 1'b1, 32'h000000FF, 4'h1);
        tbl[6] = mk(1, 1, 4, 3, -3, 1, -1,     1'b0, 32'h80817F82, 4'hF);

        bus.opsum_in       = '0;
        bus.opsum_in_last  = 1'b0;
        bus.opsum_in_valid = 1'b0;
        bus.ofmap_ready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", bus.ofmap_out, 32'd0);
        chk("rst_keep", {28'd0, bus.ofmap_keep}, 32'd0);
        chk("rst_valid", {31'd0, bus.ofmap_valid}, 32'd0);
        chk("rst_ready", {31'd0, bus.opsum_in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {29'd0, word_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            do_cfg(int'(tbl[i].scale), int'(tbl[i].shift));
            e.word = tbl[i].word;
            e.keep = tbl[i].keep;
            sb.push_back(e);
            for (int j = 0; j < int'(tbl[i].n); j++) begin
                send(int'(tbl[i].ops[j]), tbl[i].last && (j == int'(tbl[i].n) - 1), 1'b0);
            end
            drain();
            chk("vec_cnt", {29'd0, word_cnt}, 32'd1);
        end

        // Latency: word valid after the edge following acceptance of 4th opsum
        do_cfg(1, 0);
        send(1, 1'b0, 1'b1);
        send(2, 1'b0, 1'b1);
        send(3, 1'b0, 1'b1);
        send(4, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_e0_valid", {31'd0, bus.ofmap_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e1_valid", {31'd0, bus.ofmap_valid}, 32'd1);
        drain();

        // Backpressure: 8 opsums, ofmap_ready low for 5 cycles once a word is valid
        do_cfg(1, 0);
        bus.ofmap_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i * 37 - 120, 1'b0, 1'b1);
            end
            begin
                logic seen;
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    seen = bus.ofmap_valid;
                end
                chk("bp_first_valid", {31'd0, seen}, 32'd1);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", {31'd0, bus.opsum_in_ready}, 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.ofmap_ready = 1'b1;
            end
        join
        drain();
        chk("bp_cnt", {29'd0, word_cnt}, 32'd2);

        // cfg_load while busy is ignored: old scale used, counter not cleared
        send(10, 1'b0, 1'b1);
        cfg_scale = 16'd5;
        cfg_shift = 5'd1;
        cfg_load  = 1'b1;
        send(20, 1'b0, 1'b1);
        cfg_load  = 1'b0;
        send(30, 1'b0, 1'b1);
        send(-40, 1'b1, 1'b1);
        drain();
        chk("busy_cfg_cnt", {29'd0, word_cnt}, 32'd3);

        // Counter wrap: ten single-byte words
        do_cfg(1, 0);
        for (int i = 0; i < 10; i++) send(i, 1'b1, 1'b1);
        drain();
        chk("wrap_cnt", {29'd0, word_cnt}, 32'(cnt_model % (1 << CNT_BITS)));
        chk("wrap_cnt_val", {29'd0, word_cnt}, 32'd2);

        // Reset mid-word discards partial data and clears cfg
        send(50, 1'b0, 1'b1);
        send(60, 1'b0, 1'b1);
        rst = 1'b1;
        m_idx = 0;
        m_scale = 0;
        m_shift = 0;
        cnt_model = 0;
        @(negedge clk);
        chk("mid_rst_out", bus.ofmap_out, 32'd0);
        chk("mid_rst_keep", {28'd0, bus.ofmap_keep}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.ofmap_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.opsum_in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cnt", {29'd0, word_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(100, 1'b0, 1'b1);
        send(-100, 1'b0, 1'b1);
        send(7, 1'b0, 1'b1);
        send(9, 1'b0, 1'b1);
        drain();
        chk("post_rst_cnt", {29'd0, word_cnt}, 32'd1);
        do_cfg(1, 0);
        send(-3, 1'b0, 1'b1);
        send(4, 1'b0, 1'b1);
        send(-128, 1'b0, 1'b1);
        send(127, 1'b0, 1'b1);
        drain();
        chk("final_cnt", {29'd0, word_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
